// File: rtl/fetch_sequencer.sv
// Next-PC controller for the fetch stage: PC source arbitration, two-word
// I-type sequencing and the interrupt-entry handshake.
module fetch_sequencer #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(32),
  parameter logic [ADDR_W-1:0]  INT_VEC   = ADDR_W'(0),
  parameter logic [3:0]         ITYPE_OPC = 4'd8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              interrupt,
  input  logic              set_int,
  input  logic              exception,
  input  logic              pop_pc,
  input  logic [ADDR_W-1:0] popped_pc,
  input  logic              jmp_sgn,
  input  logic [ADDR_W-1:0] jmp_pc,
  input  logic              hazard_stall,
  input  logic [ADDR_W-1:0] pc_current,
  input  logic [3:0]        fetch_opcode,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_we,
  output logic              flush,
  output logic              imm_phase,
  output logic              int_taken,
  output logic [ADDR_W-1:0] ret_pc,
  output logic              int_pending
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_IMM  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              int_pending_q, int_pending_d;
  logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
  logic              irq_prev_q;

  logic [ADDR_W-1:0] pc_inc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              pend_set;
  logic              pend_clr;

  assign pc_inc = pc_current + ADDR_W'(1);

  // Shared by RUN and IMM: exception beats pop beats jump.
  always_comb begin
    redirect    = exception | pop_pc | jmp_sgn;
    redirect_pc = jmp_pc;
    if (exception) begin
      redirect_pc = RESET_VEC;
    end else if (pop_pc) begin
      redirect_pc = popped_pc;
    end
  end

  assign pend_set = (interrupt & ~irq_prev_q) | set_int;
  assign pend_clr = (state_q == S_INT) | exception;

  always_comb begin
    pc_next   = pc_inc;
    pc_we     = 1'b1;
    flush     = 1'b0;
    imm_phase = 1'b0;
    int_taken = 1'b0;
    state_d   = state_q;
    ret_pc_d  = ret_pc_q;

    if (pend_set) begin
      int_pending_d = 1'b1;
    end else if (pend_clr) begin
      int_pending_d = 1'b0;
    end else begin
      int_pending_d = int_pending_q;
    end

    unique case (state_q)
      S_BOOT: begin
        pc_next = RESET_VEC;
        flush   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          pc_next = redirect_pc;
          flush   = 1'b1;
          state_d = S_RUN;
        end else if (int_pending_q && !hazard_stall) begin
          pc_we    = 1'b0;
          flush    = 1'b1;
          ret_pc_d = pc_current;
          state_d  = S_INT;
        end else if (hazard_stall) begin
          pc_we = 1'b0;
        end else begin
          state_d = (fetch_opcode == ITYPE_OPC) ? S_IMM : S_RUN;
        end
      end
      S_IMM: begin
        imm_phase = 1'b1;
        if (redirect) begin
          pc_next = redirect_pc;
          flush   = 1'b1;
          state_d = S_RUN;
        end else if (hazard_stall) begin
          pc_we = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_INT: begin
        flush   = 1'b1;
        state_d = S_RUN;
        if (exception) begin
          pc_next = RESET_VEC;
        end else begin
          pc_next   = INT_VEC;
          int_taken = 1'b1;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase

    // Reset overrides everything, including outputs, within the same cycle.
    if (reset) begin
      pc_next   = RESET_VEC;
      pc_we     = 1'b1;
      flush     = 1'b1;
      imm_phase = 1'b0;
      int_taken = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_BOOT;
      int_pending_q <= 1'b0;
      ret_pc_q      <= '0;
      irq_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_pending_q <= int_pending_d;
      ret_pc_q      <= ret_pc_d;
      irq_prev_q    <= interrupt;
    end
  end

  assign ret_pc      = ret_pc_q;
  assign int_pending = int_pending_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural next-PC model.
module tb_fetch_sequencer;

  localparam int          AW  = 32;
  localparam logic [31:0] RV  = 32'd32;
  localparam logic [31:0] IV  = 32'd0;
  localparam logic [3:0]  OPI = 4'd8;

  logic          clk = 1'b0;
  logic          reset, interrupt, set_int, exception, pop_pc, jmp_sgn, hazard_stall;
  logic [AW-1:0] popped_pc, jmp_pc, pc_current;
  logic [3:0]    fetch_opcode;
  logic [AW-1:0] pc_next, ret_pc;
  logic          pc_we, flush, imm_phase, int_taken, int_pending;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt), .set_int(set_int),
    .exception(exception), .pop_pc(pop_pc), .popped_pc(popped_pc),
    .jmp_sgn(jmp_sgn), .jmp_pc(jmp_pc), .hazard_stall(hazard_stall),
    .pc_current(pc_current), .fetch_opcode(fetch_opcode),
    .pc_next(pc_next), .pc_we(pc_we), .flush(flush), .imm_phase(imm_phase),
    .int_taken(int_taken), .ret_pc(ret_pc), .int_pending(int_pending)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Reference model. "phase" says what the word at pc_current is:
  // 0 = booting, 1 = an opcode word, 2 = an immediate word, 3 = vector slot.
  int          m_phase = 0;
  bit          m_pend  = 0;
  logic [31:0] m_ret   = '0;
  bit          m_irq_seen = 0;
  int          taken_cnt  = 0;

  task automatic cycle();
    logic [31:0] e_next;
    bit e_we, e_fl, e_imm, e_it;
    int          n_phase;
    bit          n_pend;
    logic [31:0] n_ret;
    bit want_irq, redir;
    logic [31:0] redir_pc;
    #1;
    e_next = pc_current + 32'd1;
    e_we = 1; e_fl = 0; e_imm = 0; e_it = 0;
    n_phase = m_phase; n_pend = m_pend; n_ret = m_ret;
    redir    = exception || pop_pc || jmp_sgn;
    redir_pc = exception ? RV : (pop_pc ? popped_pc : jmp_pc);
    want_irq = (interrupt && !m_irq_seen) || set_int;

    if (reset) begin
      e_next = RV; e_fl = 1;
      n_phase = 0; n_pend = 0; n_ret = '0;
    end else begin
      if (m_phase == 0) begin
        e_next = RV; e_fl = 1; n_phase = 1;
      end else if (m_phase == 3) begin
        e_fl = 1; n_phase = 1;
        e_next = exception ? RV : IV;
        e_it   = !exception;
      end else begin
        e_imm = (m_phase == 2);
        if (redir) begin
          e_next = redir_pc; e_fl = 1; n_phase = 1;
        end else if (m_phase == 1 && m_pend && !hazard_stall) begin
          e_we = 0; e_fl = 1; n_ret = pc_current; n_phase = 3;
        end else if (hazard_stall) begin
          e_we = 0;
        end else begin
          n_phase = (m_phase == 1 && fetch_opcode == OPI) ? 2 : 1;
        end
      end
      if (want_irq) n_pend = 1;
      else if (m_phase == 3 || exception) n_pend = 0;
    end

    check_val("pc_next", pc_next, e_next);
    check_val("pc_we", 32'(pc_we), 32'(e_we));
    check_val("flush", 32'(flush), 32'(e_fl));
    check_val("imm_phase", 32'(imm_phase), 32'(e_imm));
    check_val("int_taken", 32'(int_taken), 32'(e_it));
    check_val("int_pending", 32'(int_pending), 32'(m_pend));
    check_val("ret_pc", ret_pc, m_ret);
    taken_cnt += int'(int_taken);

    @(posedge clk);
    m_phase = n_phase; m_pend = n_pend; m_ret = n_ret;
    m_irq_seen = reset ? 1'b0 : interrupt;
    @(negedge clk);
    if (e_we) pc_current = e_next;
  endtask

  task automatic quiet();
    reset = 0; interrupt = 0; set_int = 0; exception = 0; pop_pc = 0;
    jmp_sgn = 0; hazard_stall = 0; fetch_opcode = 4'd1;
    popped_pc = 32'd100; jmp_pc = 32'd200;
  endtask

  initial begin
    quiet();
    pc_current = '0;
    reset = 1;
    @(negedge clk);

    // Reset held three cycles, then BOOT, then sequential.
    for (int i = 0; i < 3; i++) begin
      pc_current = '0;
      #1 check_val("rst_pc_next", pc_next, RV);
      check_val("rst_flush", 32'(flush), 32'd1);
      cycle();
    end
    reset = 0; pc_current = '0;
    #1 check_val("boot_pc_next", pc_next, RV);
    check_val("boot_flush", 32'(flush), 32'd1);
    cycle();
    #1 check_val("first_seq", pc_next, pc_current + 32'd1);
    check_val("first_seq_flush", 32'(flush), 32'd0);
    cycle();

    // I-type: opcode word, immediate word, then back to opcodes.
    pc_current = 32'd40; fetch_opcode = OPI;
    #1 check_val("itype_next", pc_next, 32'd41);
    cycle();
    set_int = 1;
    #1 check_val("imm_phase_on", 32'(imm_phase), 32'd1);
    check_val("imm_next", pc_next, 32'd42);
    cycle();
    set_int = 0; fetch_opcode = 4'd1;
    #1 check_val("imm_phase_off", 32'(imm_phase), 32'd0);
    check_val("pend_deferred", 32'(int_pending), 32'd1);
    check_val("entry_we", 32'(pc_we), 32'd0);
    cycle();
    #1 check_val("int_vec", pc_next, IV);
    check_val("int_taken", 32'(int_taken), 32'd1);
    check_val("ret_captured", ret_pc, 32'd42);
    cycle();
    cycle();

    // Level interrupt held high: one entry; re-raise: second entry.
    taken_cnt = 0;
    interrupt = 1;
    for (int i = 0; i < 10; i++) cycle();
    check_val("irq_level_once", 32'(taken_cnt), 32'd1);
    interrupt = 0;
    cycle();
    interrupt = 1;
    for (int i = 0; i < 4; i++) cycle();
    check_val("irq_second", 32'(taken_cnt), 32'd2);
    interrupt = 0;
    cycle();

    // Simultaneous redirect sources.
    pop_pc = 1; jmp_sgn = 1; exception = 1;
    #1 check_val("exc_priority", pc_next, RV);
    cycle();
    exception = 0;
    #1 check_val("pop_priority", pc_next, 32'd100);
    check_val("pop_flush", 32'(flush), 32'd1);
    cycle();
    quiet();

    // Stall holds off a pending entry until released.
    set_int = 1;
    cycle();
    set_int = 0; hazard_stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1 check_val("stall_we", 32'(pc_we), 32'd0);
      check_val("stall_no_taken", 32'(int_taken), 32'd0);
      cycle();
    end
    hazard_stall = 0;
    pc_current = 32'd77;
    cycle();
    #1 check_val("stall_ret", ret_pc, 32'd77);
    check_val("stall_taken", 32'(int_taken), 32'd1);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 99) < 2);
      exception    = ($urandom_range(0, 99) < 5);
      pop_pc       = ($urandom_range(0, 99) < 6);
      jmp_sgn      = ($urandom_range(0, 99) < 6);
      set_int      = ($urandom_range(0, 99) < 5);
      hazard_stall = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 12) interrupt = ~interrupt;
      fetch_opcode = ($urandom_range(0, 99) < 30) ? OPI : 4'($urandom_range(0, 15));
      popped_pc    = $urandom;
      jmp_pc       = $urandom;
      if ($urandom_range(0, 99) < 3) pc_current = 32'hFFFF_FFFF;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
